// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the address/data field widths, the op encoding and the requester ids.
// The requester id becomes the MSB of the downstream opaque tag.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam logic REQ_IMEM = 1'b0;
    localparam logic REQ_DMEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Checker for the memory port arbiter: a response must never be accepted
// for a requester that has no request in flight.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   resp_hs_i   - per-requester response handshake
//   cnt_zero_i  - per-requester outstanding count is zero
module mem_port_arbiter_chk (
    input logic       clk,
    input logic       rst,
    input logic [1:0] resp_hs_i,
    input logic [1:0] cnt_zero_i
);

    a_no_underflow_imem: assert property (@(posedge clk) disable iff (rst)
        !(resp_hs_i[0] && cnt_zero_i[0]));

    a_no_underflow_dmem: assert property (@(posedge clk) disable iff (rst)
        !(resp_hs_i[1] && cnt_zero_i[1]));

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   en_i      - arbitration enable; no grant is issued while low
//   req_i     - request vector (bit 0 = imem, bit 1 = dmem)
//   gnt_o     - one-hot (or zero) grant vector
// On a tie the requester that did not win last time is granted. last_grant
// resets to dmem so that imem wins the first tie.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;
    logic [1:0] gnt_s;

    // Grant selection and last-grant next state.
    always_comb begin
        gnt_s  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (last_q == REQ_DMEM) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
        // Only an actual grant moves the round-robin pointer.
        if (gnt_s != 2'b00) begin
            last_d = gnt_s[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_DMEM;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (imem, id 0) and the
// load/store unit (dmem, id 1).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_*_i / req_rdy_i          - two upstream request channels
//   mem_req_*                    - registered downstream request, opaque = {id, opaq}
//   mem_resp_* / mem_resp_rdy    - downstream response channel
//   resp_val_o / resp_rdy_o      - per-requester response handshake
//   resp_op_o/data_o/opaq_o      - response fields broadcast to both requesters
// Requests pass through a single output register; responses are steered
// combinationally by the id bit in the returned opaque tag. Each requester is
// limited to p_max_outstanding requests in flight.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int p_opaq_bits       = 8,
    parameter int p_max_outstanding = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_val_i,
    output logic [1:0]                   req_rdy_i,
    input  logic [1:0]                   req_op_i,
    input  logic [1:0][p_opaq_bits-1:0]  req_opaq_i,
    input  logic [1:0][ADDR_W-1:0]       req_addr_i,
    input  logic [1:0][DATA_W-1:0]       req_data_i,
    output logic                         mem_req_val,
    input  logic                         mem_req_rdy,
    output logic                         mem_req_op,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [DATA_W-1:0]            mem_req_data,
    output logic [p_opaq_bits:0]         mem_req_opaq,
    input  logic                         mem_resp_val,
    output logic                         mem_resp_rdy,
    input  logic                         mem_resp_op,
    input  logic [DATA_W-1:0]            mem_resp_data,
    input  logic [p_opaq_bits:0]         mem_resp_opaq,
    output logic [1:0]                   resp_val_o,
    input  logic [1:0]                   resp_rdy_o,
    output logic                         resp_op_o,
    output logic [DATA_W-1:0]            resp_data_o,
    output logic [p_opaq_bits-1:0]       resp_opaq_o
);

    localparam int CW = $clog2(p_max_outstanding + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(p_max_outstanding);

    logic                   val_q,  val_d;
    logic                   op_q,   op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [p_opaq_bits:0]   opaq_q, opaq_d;
    logic [1:0][CW-1:0]     cnt_q,  cnt_d;

    logic       can_accept_s;
    logic [1:0] elig_s;
    logic [1:0] gnt_s;
    logic       gnt_id_s;
    logic       resp_id_s;
    logic [1:0] resp_hs_s;
    logic [1:0] cnt_zero_s;

    // Response steering: the tag MSB selects the requester.
    always_comb begin
        resp_id_s = mem_resp_opaq[p_opaq_bits];
        if (resp_id_s == REQ_DMEM) begin
            resp_val_o = {mem_resp_val, 1'b0};
        end else begin
            resp_val_o = {1'b0, mem_resp_val};
        end
        mem_resp_rdy = resp_rdy_o[resp_id_s];
        resp_hs_s    = resp_val_o & resp_rdy_o;
    end

    assign resp_op_o   = mem_resp_op;
    assign resp_data_o = mem_resp_data;
    assign resp_opaq_o = mem_resp_opaq[p_opaq_bits-1:0];

    // Eligibility. A response accepted this cycle frees a slot immediately,
    // so a requester at the limit can issue in the same cycle and its count
    // stays at the limit.
    always_comb begin
        can_accept_s = !rst && (!val_q || mem_req_rdy);
        for (int k = 0; k < 2; k++) begin
            elig_s[k] = req_val_i[k] && can_accept_s &&
                        ((cnt_q[k] < CNT_MAX) || resp_hs_s[k]);
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (can_accept_s),
        .req_i (elig_s),
        .gnt_o (gnt_s)
    );

    assign req_rdy_i = gnt_s;
    assign gnt_id_s  = gnt_s[1];

    // Output register next state: load on grant, otherwise drain on ready.
    always_comb begin
        val_d  = val_q;
        op_d   = op_q;
        addr_d = addr_q;
        data_d = data_q;
        opaq_d = opaq_q;
        if (gnt_s != 2'b00) begin
            val_d  = 1'b1;
            op_d   = req_op_i[gnt_id_s];
            addr_d = req_addr_i[gnt_id_s];
            data_d = req_data_i[gnt_id_s];
            opaq_d = {gnt_id_s, req_opaq_i[gnt_id_s]};
        end else if (mem_req_rdy) begin
            val_d  = 1'b0;
        end else begin
            val_d  = val_q;
        end
    end

    // Outstanding counters: grant increments, response handshake decrements.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_zero_s[k] = (cnt_q[k] == CW'(0));
            case ({gnt_s[k], resp_hs_s[k]})
                2'b10: cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01: begin
                    if (cnt_zero_s[k]) begin
                        cnt_d[k] = cnt_q[k];
                    end else begin
                        cnt_d[k] = cnt_q[k] - CW'(1);
                    end
                end
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    // State registers; reset drops the buffered request and clears counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= 1'b0;
            op_q   <= 1'b0;
            addr_q <= {ADDR_W{1'b0}};
            data_q <= {DATA_W{1'b0}};
            opaq_q <= {(p_opaq_bits + 1){1'b0}};
            cnt_q  <= {(2 * CW){1'b0}};
        end else begin
            val_q  <= val_d;
            op_q   <= op_d;
            addr_q <= addr_d;
            data_q <= data_d;
            opaq_q <= opaq_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mem_req_val  = val_q;
    assign mem_req_op   = op_q;
    assign mem_req_addr = addr_q;
    assign mem_req_data = data_q;
    assign mem_req_opaq = opaq_q;

    mem_port_arbiter_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .resp_hs_i  (resp_hs_s),
        .cnt_zero_i (cnt_zero_s)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_val;
    logic [1:0]        req_rdy;
    logic [1:0]        req_op;
    logic [1:0][7:0]   req_opaq;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_data;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic              mem_req_op;
    logic [31:0]       mem_req_addr;
    logic [31:0]       mem_req_data;
    logic [8:0]        mem_req_opaq;
    logic              mem_resp_val;
    logic              mem_resp_rdy;
    logic              mem_resp_op;
    logic [31:0]       mem_resp_data;
    logic [8:0]        mem_resp_opaq;
    logic [1:0]        resp_val;
    logic [1:0]        resp_rdy;
    logic              resp_op;
    logic [31:0]       resp_data;
    logic [7:0]        resp_opaq;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.p_opaq_bits(8), .p_max_outstanding(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val_i     (req_val),
        .req_rdy_i     (req_rdy),
        .req_op_i      (req_op),
        .req_opaq_i    (req_opaq),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_op    (mem_req_op),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_opaq  (mem_req_opaq),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_rdy  (mem_resp_rdy),
        .mem_resp_op   (mem_resp_op),
        .mem_resp_data (mem_resp_data),
        .mem_resp_opaq (mem_resp_opaq),
        .resp_val_o    (resp_val),
        .resp_rdy_o    (resp_rdy),
        .resp_op_o     (resp_op),
        .resp_data_o   (resp_data),
        .resp_opaq_o   (resp_opaq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_val       = 2'b00;
        req_op        = 2'b00;
        req_opaq      = '0;
        req_addr      = '0;
        req_data      = '0;
        mem_req_rdy   = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_op   = 1'b0;
        mem_resp_data = 32'h0;
        mem_resp_opaq = 9'h000;
        resp_rdy      = 2'b11;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        req_val = 2'b11;
        #1;
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++; $display("FAIL reset_rdy: got %b expected 00", req_rdy);
        end
        step();
        checks++;
        if (mem_req_val !== 1'b0) begin
            errors++; $display("FAIL reset_val: got %b expected 0", mem_req_val);
        end
        checks++;
        if (dut.cnt_q[0] !== 3'd0 || dut.cnt_q[1] !== 3'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", dut.cnt_q[0], dut.cnt_q[1]);
        end
        rst = 1'b0;
        req_val = 2'b00;
    endtask

    task automatic test_single_read();
        do_reset();
        req_val[0] = 1'b1; req_op[0] = 1'b0; req_addr[0] = 32'h200; req_opaq[0] = 8'h05;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL single_rdy: got %b expected 01", req_rdy);
        end
        step();
        req_val = 2'b00;
        mem_req_rdy = 1'b1;
        checks++;
        if (mem_req_val !== 1'b1 || mem_req_opaq !== 9'h005 || mem_req_addr !== 32'h200 || mem_req_op !== 1'b0) begin
            errors++; $display("FAIL single_req: got val=%b opaq=%h addr=%h op=%b expected 1 005 00000200 0",
                               mem_req_val, mem_req_opaq, mem_req_addr, mem_req_op);
        end
        step();
        mem_req_rdy = 1'b0;
        checks++;
        if (mem_req_val !== 1'b0) begin
            errors++; $display("FAIL single_drain: got %b expected 0", mem_req_val);
        end
        mem_resp_val = 1'b1; mem_resp_opaq = 9'h005; mem_resp_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (resp_val !== 2'b01 || resp_opaq !== 8'h05 || resp_data !== 32'hDEADBEEF || mem_resp_rdy !== 1'b1) begin
            errors++; $display("FAIL single_resp: got val=%b opaq=%h data=%h rdy=%b expected 01 05 deadbeef 1",
                               resp_val, resp_opaq, resp_data, mem_resp_rdy);
        end
        step();
        mem_resp_val = 1'b0;
        checks++;
        if (dut.cnt_q[0] !== 3'd0) begin
            errors++; $display("FAIL single_cnt: got %0d expected 0", dut.cnt_q[0]);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        do_reset();
        mem_req_rdy = 1'b1;
        req_val = 2'b11;
        req_addr[0] = 32'h100; req_addr[1] = 32'h800;
        exp_g = 2'b01;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (req_rdy !== exp_g) begin
                errors++; $display("FAIL alt_grant%0d: got %b expected %b", i, req_rdy, exp_g);
            end
            step();
            checks++;
            if (mem_req_val !== 1'b1 || mem_req_opaq[8] !== exp_g[1]) begin
                errors++; $display("FAIL alt_out%0d: got val=%b id=%b expected 1 %b", i, mem_req_val, mem_req_opaq[8], exp_g[1]);
            end
            exp_g = ~exp_g;
        end
        req_val = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_val = 2'b10; req_op[1] = 1'b1; req_addr[1] = 32'h1000; req_data[1] = 32'hCAFEF00D; req_opaq[1] = 8'h22;
        step();
        req_val = 2'b01; req_op[0] = 1'b0; req_addr[0] = 32'h40; req_opaq[0] = 8'h11;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_rdy !== 2'b00 || mem_req_val !== 1'b1 || mem_req_addr !== 32'h1000 ||
                mem_req_data !== 32'hCAFEF00D || mem_req_op !== 1'b1 || mem_req_opaq !== 9'h122) begin
                errors++; $display("FAIL bp_hold%0d: got rdy=%b val=%b addr=%h data=%h op=%b opaq=%h expected 00 1 00001000 cafef00d 1 122",
                                   i, req_rdy, mem_req_val, mem_req_addr, mem_req_data, mem_req_op, mem_req_opaq);
            end
            step();
        end
        mem_req_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL bp_drain_grant: got %b expected 01", req_rdy);
        end
        step();
        req_val = 2'b00;
        checks++;
        if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h40 || mem_req_opaq !== 9'h011) begin
            errors++; $display("FAIL bp_next: got val=%b addr=%h opaq=%h expected 1 00000040 011", mem_req_val, mem_req_addr, mem_req_opaq);
        end
    endtask

    task automatic test_limit();
        do_reset();
        mem_req_rdy = 1'b1;
        req_val = 2'b10;
        for (int i = 0; i < 4; i++) begin
            req_addr[1] = 32'h2000 + 32'(i * 4);
            #1;
            checks++;
            if (req_rdy !== 2'b10) begin
                errors++; $display("FAIL limit_issue%0d: got %b expected 10", i, req_rdy);
            end
            step();
        end
        req_val = 2'b11;
        #1;
        checks++;
        if (req_rdy !== 2'b01 || dut.cnt_q[1] !== 3'd4) begin
            errors++; $display("FAIL limit_stall: got rdy=%b cnt=%0d expected 01 4", req_rdy, dut.cnt_q[1]);
        end
        step();
        mem_resp_val = 1'b1; mem_resp_opaq = 9'h100; resp_rdy = 2'b10;
        #1;
        checks++;
        if (req_rdy !== 2'b10) begin
            errors++; $display("FAIL limit_reissue: got %b expected 10", req_rdy);
        end
        step();
        mem_resp_val = 1'b0; req_val = 2'b00; resp_rdy = 2'b11;
        checks++;
        if (dut.cnt_q[1] !== 3'd4 || dut.cnt_q[0] !== 3'd1) begin
            errors++; $display("FAIL limit_cnt: got %0d/%0d expected 1/4", dut.cnt_q[0], dut.cnt_q[1]);
        end
    endtask

    task automatic test_resp_backpressure();
        mem_resp_val = 1'b1; mem_resp_opaq = 9'h1A3; mem_resp_data = 32'h12345678; resp_rdy = 2'b01;
        #1;
        checks++;
        if (mem_resp_rdy !== 1'b0 || resp_val !== 2'b10 || resp_opaq !== 8'hA3) begin
            errors++; $display("FAIL rbp_hold: got rdy=%b val=%b opaq=%h expected 0 10 a3", mem_resp_rdy, resp_val, resp_opaq);
        end
        step();
        checks++;
        if (dut.cnt_q[1] !== 3'd4) begin
            errors++; $display("FAIL rbp_cnt_hold: got %0d expected 4", dut.cnt_q[1]);
        end
        resp_rdy = 2'b11;
        #1;
        checks++;
        if (mem_resp_rdy !== 1'b1) begin
            errors++; $display("FAIL rbp_rdy: got %b expected 1", mem_resp_rdy);
        end
        step();
        mem_resp_val = 1'b0;
        checks++;
        if (dut.cnt_q[1] !== 3'd3) begin
            errors++; $display("FAIL rbp_cnt_dec: got %0d expected 3", dut.cnt_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_req_rdy = 1'b1;
        req_val = 2'b11;
        for (int i = 0; i < 4; i++) step();
        req_val = 2'b10;
        step();
        req_val = 2'b00; mem_req_rdy = 1'b0;
        #1;
        checks++;
        if (mem_req_val !== 1'b1 || dut.cnt_q[0] !== 3'd2 || dut.cnt_q[1] !== 3'd3) begin
            errors++; $display("FAIL mid_setup: got val=%b cnt=%0d/%0d expected 1 2/3", mem_req_val, dut.cnt_q[0], dut.cnt_q[1]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (mem_req_val !== 1'b0 || dut.cnt_q[0] !== 3'd0 || dut.cnt_q[1] !== 3'd0) begin
            errors++; $display("FAIL mid_reset: got val=%b cnt=%0d/%0d expected 0 0/0", mem_req_val, dut.cnt_q[0], dut.cnt_q[1]);
        end
        req_val = 2'b11; mem_req_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL mid_tie: got %b expected 01", req_rdy);
        end
        step();
        req_val = 2'b00;
        checks++;
        if (mem_req_val !== 1'b1 || mem_req_opaq[8] !== 1'b0) begin
            errors++; $display("FAIL mid_first: got val=%b id=%b expected 1 0", mem_req_val, mem_req_opaq[8]);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_alternate();
        test_backpressure();
        test_limit();
        test_resp_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
